alu_serial: RTL and testbench

ALU_SERIAL -- requirements
Module: alu_serial

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_chunk.sv | 41 ++++
 rtl/alu_serial.sv | 155 +++++++++++++++
 tb/tb_alu_serial.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared op encodings and FSM state type for the serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_chunk.sv
// ============================================================================
// Module      : alu_chunk
// Description : Combinational CHUNK-bit ALU slice with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_chunk
    import alu_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [1:0]       op,
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    input  logic             cin,
    output logic [CHUNK-1:0] o_chunk,
    output logic             cout
);

    logic [CHUNK-1:0] w_b_eff;
    logic [CHUNK:0]   w_sum;

    always_comb begin
        w_b_eff = (op == OP_SUB) ? ~b_chunk : b_chunk;
        w_sum   = {1'b0, a_chunk} + {1'b0, w_b_eff} + {{CHUNK{1'b0}}, cin};
        o_chunk = '0;
        cout    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                o_chunk = w_sum[CHUNK-1:0];
                cout    = w_sum[CHUNK];
            end
            OP_NAND: o_chunk = ~(a_chunk & b_chunk);
            default: o_chunk = a_chunk | b_chunk;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ============================================================================
// Module      : alu_serial
// Description : Bit-serial (CHUNK bits/cycle) ALU with valid/ready handshakes.
//               Optional zero/ovf outputs enabled by macro ALU_SERIAL_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int C_N     = WIDTH / CHUNK;
    localparam int C_CNT_W = (C_N > 1) ? $clog2(C_N) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(C_N - 1);

    generate
        if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_bad_cfg
            $error("alu_serial: WIDTH must be a multiple of CHUNK and CHUNK <= WIDTH");
        end
    endgenerate

    state_t             r_state_q, w_state_d;
    logic [1:0]         r_op_q,    w_op_d;
    logic [WIDTH-1:0]   r_a_q,     w_a_d;
    logic [WIDTH-1:0]   r_b_q,     w_b_d;
    logic [WIDTH-1:0]   r_res_q,   w_res_d;
    logic               r_carry_q, w_carry_d;
    logic [C_CNT_W-1:0] r_cnt_q,   w_cnt_d;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic [CHUNK-1:0]   w_o_chunk;
    logic               w_chunk_cout;

    assign w_a_chunk = r_a_q[int'(r_cnt_q) * CHUNK +: CHUNK];
    assign w_b_chunk = r_b_q[int'(r_cnt_q) * CHUNK +: CHUNK];

    alu_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .op      (r_op_q),
        .a_chunk (w_a_chunk),
        .b_chunk (w_b_chunk),
        .cin     (r_carry_q),
        .o_chunk (w_o_chunk),
        .cout    (w_chunk_cout)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_op_d    = r_op_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_carry_d = r_carry_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            S_IDLE: begin
                if (in_valid) begin
                    w_op_d    = op;
                    w_a_d     = a;
                    w_b_d     = b;
                    // SUB's +1 enters as the initial carry into the LSB chunk
                    w_carry_d = (op == OP_SUB);
                    w_cnt_d   = '0;
                    w_state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                w_res_d[int'(r_cnt_q) * CHUNK +: CHUNK] = w_o_chunk;
                w_carry_d = w_chunk_cout;
                if (r_cnt_q == C_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = S_DONE;
                end else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_op_q    <= '0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_carry_q <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_op_q    <= w_op_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_carry_q <= w_carry_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign in_ready  = (r_state_q == S_IDLE);
    assign out_valid = (r_state_q == S_DONE);
    assign result    = r_res_q;
    assign cout      = r_carry_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic w_ovf_raw;

    // Signed overflow: operands (b inverted for SUB) agree in sign but result differs
    always_comb begin
        w_ovf_raw = 1'b0;
        case (r_op_q)
            OP_ADD:  w_ovf_raw = (r_a_q[WIDTH-1] == r_b_q[WIDTH-1]) &&
                                 (r_res_q[WIDTH-1] != r_a_q[WIDTH-1]);
            OP_SUB:  w_ovf_raw = (r_a_q[WIDTH-1] != r_b_q[WIDTH-1]) &&
                                 (r_res_q[WIDTH-1] != r_a_q[WIDTH-1]);
            default: w_ovf_raw = 1'b0;
        endcase
    end

    assign zero = out_valid && (r_res_q == '0);
    assign ovf  = out_valid && w_ovf_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// ============================================================================
// Module      : tb_alu_serial
// Description : Scoreboard bench for alu_serial (WIDTH=8 CHUNK=2, plus CHUNK=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_serial;
    import alu_pkg::*;

    localparam int C_N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] op = 2'b00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       cout;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [1:0] op8 = 2'b00;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       out_valid8;
    logic [7:0] result8;
    logic       cout8;

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero, ovf, zero8, ovf8;
`endif

    alu_serial #(.WIDTH(8), .CHUNK(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zero(zero), .ovf(ovf)
`endif
    );

    alu_serial #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(1'b1),
        .result(result8), .cout(cout8)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zero(zero8), .ovf(ovf8)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       v;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops on the first DONE cycle, then checks hold while stalled
    initial begin : monitor
        exp_t cur;
        bit   seen;
        seen = 1'b0;
        cur  = '{res: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0, acc: 0};
        forever begin
            @(negedge clk);
            if (!out_valid) seen = 1'b0;
            if (!rst && out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        cur  = sb.pop_front();
                        seen = 1'b1;
                        chk("latency", 32'(cyc - cur.acc - 1), 32'(C_N));
                        chk("result", 32'(result), 32'(cur.res));
                        chk("cout", 32'(cout), 32'(cur.c));
`ifdef ALU_SERIAL_FLAGS_EN
                        chk("zero", 32'(zero), 32'(cur.z));
                        chk("ovf", 32'(ovf), 32'(cur.v));
`endif
                    end
                end else begin
                    chk("hold_result", 32'(result), 32'(cur.res));
                    chk("hold_cout", 32'(cout), 32'(cur.c));
                end
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready) seen = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge
    task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] er, input logic ec, input logic ez,
                         input logic ev, input bit push);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        for (int k = 0; k < 60; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{res: er, c: ec, z: ez, v: ev, acc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
        op       = ~o;
        a        = ~x;
        b        = 8'hA5;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0 && !out_valid) return;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_out_valid();
        for (int k = 0; k < 40; k++) begin
            if (out_valid) return;
            @(negedge clk);
        end
        chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin : driver
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);

        //      op       a      b      result c  z  v
        issue(OP_ADD,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
        issue(OP_SUB,  8'h05, 8'h07, 8'hFE, 0, 0, 0, 1);
        issue(OP_SUB,  8'h03, 8'h03, 8'h00, 1, 1, 0, 1);
        issue(OP_NAND, 8'hF0, 8'hCC, 8'h3F, 0, 0, 0, 1);
        issue(OP_OR,   8'hF0, 8'hCC, 8'hFC, 0, 0, 0, 1);
        issue(OP_ADD,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 1);
        issue(OP_SUB,  8'h80, 8'h01, 8'h7F, 1, 0, 1, 1);
        issue(OP_ADD,  8'h3C, 8'h5A, 8'h96, 0, 0, 1, 1);
        drain();

        // Backpressure: stall 3 cycles in DONE with stray in_valid pulses
        out_ready = 1'b0;
        issue(OP_ADD, 8'h12, 8'h34, 8'h46, 0, 0, 0, 1);
        wait_out_valid();
        op = OP_OR;
        a  = 8'hFF;
        b  = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            in_valid = (k != 1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during BUSY aborts the request without any out_valid
        issue(OP_ADD, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
`ifdef ALU_SERIAL_FLAGS_EN
        chk("abort_zero", 32'(zero), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
`endif
        repeat (6) @(negedge clk);
        issue(OP_ADD, 8'h0A, 8'h0B, 8'h15, 0, 0, 0, 1);
        drain();

        // Single-chunk configuration: one BUSY cycle
        chk("c8_in_ready", 32'(in_ready8), 32'd1);
        in_valid8 = 1'b1;
        op8       = OP_ADD;
        a8        = 8'hFF;
        b8        = 8'h01;
        @(negedge clk);
        in_valid8 = 1'b0;
        a8        = 8'h00;
        chk("c8_busy_out_valid", 32'(out_valid8), 32'd0);
        @(negedge clk);
        chk("c8_out_valid", 32'(out_valid8), 32'd1);
        chk("c8_result", 32'(result8), 32'h00);
        chk("c8_cout", 32'(cout8), 32'd1);
`ifdef ALU_SERIAL_FLAGS_EN
        chk("c8_zero", 32'(zero8), 32'd1);
        chk("c8_ovf", 32'(ovf8), 32'd0);
`endif
        @(negedge clk);
        chk("c8_idle", 32'(in_ready8), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
